vector_list_fetch: RTL and testbench

//  Reader side of the display-list RAM. memory_manage writes the list and raises go;

---
 rtl/vector_list_fetch.sv | 144 ++++++++++++++
 tb/tb_vector_list_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_fetch.sv
// rtl/vector_list_fetch.sv - display-list reader: fetch, decode MOVE/LINE/NOP/END, emit beam commands
module vector_list_fetch #(
  parameter int ADDRESSWIDTH = 10,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int LIST_DEPTH   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic [ADDRESSWIDTH-1:0] addr,
  output logic                    halt,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [OUT_WIDTH-1:0]    cmd_x,
  output logic [OUT_WIDTH-1:0]    cmd_y,
  output logic                    cmd_draw,
  output logic                    err_overrun
);

  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(LIST_DEPTH - 1);

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LINE = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    go_q;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [OUT_WIDTH-1:0]    cmd_x_q, cmd_x_d;
  logic [OUT_WIDTH-1:0]    cmd_y_q, cmd_y_d;
  logic                    cmd_draw_q, cmd_draw_d;
  logic                    err_q, err_d;

  logic       go_rise;
  logic       at_last;
  logic [1:0] opcode;

  assign go_rise = go & ~go_q;
  assign at_last = (addr_q == LAST_ADDR);
  assign opcode  = data_in[DATAWIDTH-1 -: 2];

  // State and datapath registers; reset drops any pending command without a halt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      addr_q     <= '0;
      cmd_x_q    <= '0;
      cmd_y_q    <= '0;
      cmd_draw_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go;
      addr_q     <= addr_d;
      cmd_x_q    <= cmd_x_d;
      cmd_y_q    <= cmd_y_d;
      cmd_draw_q <= cmd_draw_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: walk the list, stop on END or at the last legal address
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cmd_x_d    = cmd_x_q;
    cmd_y_d    = cmd_y_q;
    cmd_draw_d = cmd_draw_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (go_rise) begin
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_END: state_d = DONE;
          OP_NOP: begin
            if (at_last) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              addr_d  = addr_q + ADDRESSWIDTH'(1);
              state_d = FETCH;
            end
          end
          default: begin
            cmd_x_d    = data_in[2*OUT_WIDTH-1:OUT_WIDTH];
            cmd_y_d    = data_in[OUT_WIDTH-1:0];
            cmd_draw_d = (opcode == OP_LINE);
            state_d    = EMIT;
          end
        endcase
      end
      EMIT: begin
        if (cmd_ready) begin
          if (at_last) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDRESSWIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset clears valid/halt/addr immediately
  always_comb begin
    addr        = (state_q == IDLE) ? '0 : addr_q;
    halt        = (state_q == DONE);
    cmd_valid   = (state_q == EMIT);
    cmd_x       = cmd_x_q;
    cmd_y       = cmd_y_q;
    cmd_draw    = cmd_draw_q;
    err_overrun = err_q;
  end

endmodule

// File: tb/tb_vector_list_fetch.sv
// tb/tb_vector_list_fetch.sv - scoreboard bench for vector_list_fetch
module tb_vector_list_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [17:0] data_in;
  logic [9:0]  addr;
  logic        halt;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_draw;
  logic        err_overrun;

  logic [17:0] ram [0:1023];
  logic [16:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          halt_count = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_cmd = '0;

  vector_list_fetch #(
    .ADDRESSWIDTH(10),
    .DATAWIDTH(18),
    .OUT_WIDTH(8),
    .LIST_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .data_in(data_in),
    .addr(addr),
    .halt(halt),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_draw(cmd_draw),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_in <= ram[addr];

  function automatic logic [17:0] w(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    return {op, x, y};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected commands on handshake, checks hold-while-stalled and halt exclusivity
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("hold_cmd", {15'd0, cmd_x, cmd_y, cmd_draw}, {15'd0, prev_cmd});
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got x=%0d y=%0d draw=%0d required none", cmd_x, cmd_y, cmd_draw);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("cmd", {15'd0, cmd_x, cmd_y, cmd_draw}, {15'd0, e});
        end
      end
      if (halt) begin
        halt_count++;
        check("halt_excl_valid", {31'd0, cmd_valid}, 32'd0);
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd   = {cmd_x, cmd_y, cmd_draw};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 1024; i++) ram[i] = w(2'b11, 8'd0, 8'd0);
  endtask

  task automatic settle_go_low();
    go = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_halt(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (halt) break;
    end
    if (!halt) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: got no halt required halt within %0d cycles", budget);
    end
  endtask

  task automatic run_frame(input int budget, output int n, output int first_valid);
    n = 0;
    first_valid = -1;
    go = 1'b1;
    while (n < budget) begin
      tick();
      n++;
      if (cmd_valid && first_valid < 0) first_valid = n;
      if (halt) break;
    end
    if (!halt) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no halt required halt within %0d cycles", budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!cmd_valid && n < budget) begin
      tick();
      n++;
    end
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got cmd_valid=0 required 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    int n, f, h0;
    rst = 1'b1;
    go = 1'b0;
    cmd_ready = 1'b1;
    clear_ram();
    repeat (3) tick();
    check("reset_addr", {22'd0, addr}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_err", {31'd0, err_overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: MOVE(10,20), LINE(30,40), END with ready always high
    clear_ram();
    ram[0] = w(2'b00, 8'd10, 8'd20);
    ram[1] = w(2'b01, 8'd30, 8'd40);
    ram[2] = w(2'b11, 8'd0, 8'd0);
    exp_q.push_back({8'd10, 8'd20, 1'b0});
    exp_q.push_back({8'd30, 8'd40, 1'b1});
    h0 = halt_count;
    run_frame(50, n, f);
    check("t1_first_valid_cycle", f, 3);
    check("t1_halt_cycle", n, 9);
    tick();
    check("t1_addr_back_0", {22'd0, addr}, 32'd0);
    check("t1_halt_low", {31'd0, halt}, 32'd0);
    check("t1_err", {31'd0, err_overrun}, 32'd0);
    tick();
    check("t1_halt_count", halt_count - h0, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    settle_go_low();

    // 2: same list, first command stalled for 5 cycles
    exp_q.push_back({8'd10, 8'd20, 1'b0});
    exp_q.push_back({8'd30, 8'd40, 1'b1});
    h0 = halt_count;
    cmd_ready = 1'b0;
    go = 1'b1;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid_held", {31'd0, cmd_valid}, 32'd1);
      check("t2_addr_held", {22'd0, addr}, 32'd0);
      check("t2_x_held", {24'd0, cmd_x}, 32'd10);
    end
    cmd_ready = 1'b1;
    wait_halt(50, n);
    repeat (2) tick();
    check("t2_halt_count", halt_count - h0, 1);
    check("t2_queue_empty", exp_q.size(), 0);
    settle_go_low();

    // 3: NOP, NOP, LINE(255,0), END
    clear_ram();
    ram[0] = w(2'b10, 8'd0, 8'd0);
    ram[1] = w(2'b10, 8'd0, 8'd0);
    ram[2] = w(2'b01, 8'd255, 8'd0);
    ram[3] = w(2'b11, 8'd0, 8'd0);
    exp_q.push_back({8'd255, 8'd0, 1'b1});
    h0 = halt_count;
    run_frame(50, n, f);
    check("t3_first_valid_cycle", f, 7);
    check("t3_halt_cycle", n, 10);
    repeat (2) tick();
    check("t3_halt_count", halt_count - h0, 1);
    check("t3_queue_empty", exp_q.size(), 0);
    settle_go_low();

    // 4: eight LINE words, no END, list depth 8 -> overrun
    clear_ram();
    for (int i = 0; i < 8; i++) begin
      ram[i] = w(2'b01, 8'(i * 16 + 1), 8'(200 - i));
      exp_q.push_back({8'(i * 16 + 1), 8'(200 - i), 1'b1});
    end
    h0 = halt_count;
    run_frame(100, n, f);
    check("t4_halt_cycle", n, 25);
    tick();
    check("t4_err_set", {31'd0, err_overrun}, 32'd1);
    check("t4_addr_back_0", {22'd0, addr}, 32'd0);
    tick();
    check("t4_halt_count", halt_count - h0, 1);
    check("t4_queue_empty", exp_q.size(), 0);
    settle_go_low();
    check("t4_err_sticky", {31'd0, err_overrun}, 32'd1);
    ram[0] = w(2'b11, 8'd0, 8'd0);
    go = 1'b1;
    tick();
    check("t4_err_cleared", {31'd0, err_overrun}, 32'd0);
    wait_halt(20, n);
    tick();
    check("t4_err_after_end", {31'd0, err_overrun}, 32'd0);
    settle_go_low();

    // 5: reset while in EMIT, go held high through reset
    clear_ram();
    ram[0] = w(2'b00, 8'd1, 8'd2);
    ram[1] = w(2'b11, 8'd0, 8'd0);
    h0 = halt_count;
    cmd_ready = 1'b0;
    go = 1'b1;
    wait_valid(20);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("t5_rst_halt", {31'd0, halt}, 32'd0);
    check("t5_rst_addr", {22'd0, addr}, 32'd0);
    tick();
    cmd_ready = 1'b1;
    exp_q.push_back({8'd1, 8'd2, 1'b0});
    rst = 1'b0;
    wait_halt(30, n);
    check("t5_restart_halt_cycle", n, 6);
    repeat (2) tick();
    check("t5_halt_count", halt_count - h0, 1);
    check("t5_queue_empty", exp_q.size(), 0);
    settle_go_low();

    // 6: go toggled mid-frame, then held high after halt
    clear_ram();
    ram[0] = w(2'b00, 8'd10, 8'd20);
    ram[1] = w(2'b01, 8'd30, 8'd40);
    ram[2] = w(2'b11, 8'd0, 8'd0);
    exp_q.push_back({8'd10, 8'd20, 1'b0});
    exp_q.push_back({8'd30, 8'd40, 1'b1});
    h0 = halt_count;
    go = 1'b1;
    repeat (2) tick();
    go = 1'b0;
    tick();
    go = 1'b1;
    wait_halt(50, n);
    repeat (12) tick();
    check("t6_halt_count", halt_count - h0, 1);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_addr_idle", {22'd0, addr}, 32'd0);
    settle_go_low();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
